// File: rtl/decoder_scan_n_to_m.sv
// decoder_scan_n_to_m: registered N-to-2^N one-hot decoder with a scan mode.
// DECODE holds the one-hot line selected at load time; SCAN walks the line
// through all 2^N outputs, holding each for dwell+1 cycles.
// Optional macro DECODER_SCAN_DIR_EN adds a 'dir' input (0 = up, 1 = down)
// that is captured on load and sets the scan direction.
module decoder_scan_n_to_m #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic              mode,
  input  logic [N-1:0]      in,
  input  logic [DWELL_W-1:0] dwell,
`ifdef DECODER_SCAN_DIR_EN
  input  logic              dir,
`endif
  output logic [2**N-1:0]   out,
  output logic              valid,
  output logic              wrap,
  output logic              busy
);

  localparam int M = 2**N;

  localparam logic [N-1:0]       IDX_ONE  = 1;
  localparam logic [N-1:0]       IDX_LAST = '1;
  localparam logic [N-1:0]       IDX_ZERO = '0;
  localparam logic [DWELL_W-1:0] CNT_ONE  = 1;
  localparam logic [DWELL_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [N-1:0]         idx, idx_nxt;
  logic [DWELL_W-1:0]   dwell_reg, dwell_nxt;
  logic [DWELL_W-1:0]   cnt, cnt_nxt;
  logic                 wrap_nxt;
  logic [M-1:0]         out_nxt;
  logic                 valid_nxt;
`ifdef DECODER_SCAN_DIR_EN
  logic                 dir_reg, dir_nxt;
`endif

  // State, datapath and output registers; everything visible is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      dwell_reg <= '0;
      cnt       <= '0;
      out       <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
`ifdef DECODER_SCAN_DIR_EN
      dir_reg   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      dwell_reg <= dwell_nxt;
      cnt       <= cnt_nxt;
      out       <= out_nxt;
      valid     <= valid_nxt;
      wrap      <= wrap_nxt;
`ifdef DECODER_SCAN_DIR_EN
      dir_reg   <= dir_nxt;
`endif
    end
  end

  // Next-state logic: enable gating wins over load, load wins over scan advance.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell_reg;
    cnt_nxt   = cnt;
    wrap_nxt  = 1'b0;
`ifdef DECODER_SCAN_DIR_EN
    dir_nxt   = dir_reg;
`endif
    if (!enable) begin
      state_nxt = IDLE;
    end else if (load) begin
      idx_nxt   = in;
      dwell_nxt = dwell;
      cnt_nxt   = dwell;
      state_nxt = mode ? SCAN : DECODE;
`ifdef DECODER_SCAN_DIR_EN
      dir_nxt   = dir;
`endif
    end else if (state == SCAN) begin
      if (cnt != CNT_ZERO) begin
        cnt_nxt = cnt - CNT_ONE;
      end else begin
        cnt_nxt = dwell_reg;
`ifdef DECODER_SCAN_DIR_EN
        if (dir_reg) begin
          idx_nxt  = idx - IDX_ONE;
          wrap_nxt = (idx == IDX_ZERO);
        end else begin
          idx_nxt  = idx + IDX_ONE;
          wrap_nxt = (idx == IDX_LAST);
        end
`else
        idx_nxt  = idx + IDX_ONE;
        wrap_nxt = (idx == IDX_LAST);
`endif
      end
    end
  end

  // Output decode from the next state so out switches directly line to line.
  always_comb begin
    out_nxt   = '0;
    valid_nxt = 1'b0;
    if (state_nxt != IDLE) begin
      out_nxt[idx_nxt] = 1'b1;
      valid_nxt        = 1'b1;
    end
  end

  assign busy = (state == SCAN);

endmodule

// File: doc/decoder_scan_n_to_m.md
Name: decoder_scan_n_to_m

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; the successor to the team's combinational 1-to-2 decoder.
- Two modes:
  - DECODE: latches an index and holds the matching one-hot output.
  - SCAN: walks the one-hot output through all 2^N lines, with a programmable dwell time per line.
- Drives row/segment/chip-select style one-hot lines in display and bus-select logic, where glitch-free registered outputs are required.

Parameters:
- N, 3, input index width; output width M = 2**N (derived localparam, not overridable).
- DWELL_W, 4, width of the dwell (cycles-per-line) field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  active-high block enable; 0 forces outputs off.
- load  input  1  single-cycle strobe; captures mode, in, dwell.
- mode  input  1  0 = DECODE, 1 = SCAN; sampled only on load.
- in  input  N  decode index (DECODE) or start index (SCAN); sampled only on load.
- dwell  input  DWELL_W  extra cycles each line is held in SCAN; sampled only on load.
- out  output  M  registered one-hot output.
- valid  output  1  1 whenever out is non-zero.
- wrap  output  1  one-cycle pulse when SCAN index wraps M-1 -> 0.
- busy  output  1  1 while in SCAN state.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, held until the first clk edge after rst_n rises:
  - out = 0, valid = 0, wrap = 0, busy = 0.
  - state = IDLE; internal idx = 0, dwell_reg = 0, cnt = 0.
- All outputs are registered and update only on clk rising edge.
- Latency: load to first out update is 1 cycle.
- States:
  - IDLE: out = 0.
  - DECODE: out = 1 << idx, static.
  - SCAN: out = 1 << idx, advancing.
- Priority per cycle: enable = 0 > load > scan advance.
- enable = 0 (any state):
  - Next edge: state = IDLE, out = 0, valid = 0, busy = 0, wrap = 0.
  - load is ignored while enable = 0.
  - Latched idx and dwell_reg are retained but unused.
- enable = 1 and load = 1 (any state, including mid-scan):
  - idx <= in; dwell_reg <= dwell; cnt <= dwell.
  - mode = 0 -> DECODE; mode = 1 -> SCAN.
  - Next cycle: out = 1 << in, valid = 1.
  - A load during SCAN restarts the scan; no wrap is issued for that cycle.
- DECODE with no load: out holds; in and dwell changes have no effect.
- SCAN with no load:
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: idx <= idx + 1 (mod M) and cnt <= dwell_reg.
  - Each line is therefore visible for dwell_reg + 1 cycles; dwell = 0 advances every cycle.
- wrap = 1 for exactly the cycle in which out first shows bit 0 after bit M-1. It is registered with out, so they stay aligned.
- Invariant: out is always zero or exactly one-hot; never multi-hot, including across state changes (out switches directly old line -> new line).
- valid = |out; busy = (state == SCAN).
- Arithmetic: idx is N bits with natural wrap; cnt is DWELL_W bits and never underflows.
- Async reset mid-scan or mid-decode: immediate return to reset values; no partial state survives.

Optional Feature:
- Macro: DECODER_SCAN_DIR_EN.
- Defined:
  - Adds port dir (input, 1 bit), sampled on load: 0 = up, 1 = down.
  - Down scan: idx <= idx - 1 (mod M).
  - wrap pulses when out first shows bit M-1 after bit 0.
  - DECODE is unaffected by dir.
- Not defined: no dir port; scan is always up. Behaviour is exactly as in Behaviour.

Test Plan (N = 3, DWELL_W = 4):
- Reset/decode: rst_n low then high, enable = 1, load with mode = 0, in = 5 -> next cycle out = 8'b0010_0000, valid = 1, busy = 0; out holds while in changes freely.
- Enable gating: in DECODE with out = 8'h20, drop enable for 1 cycle -> next cycle out = 0, valid = 0; load pulsed with enable = 0 -> out stays 0.
- Scan with dwell: load mode = 1, in = 6, dwell = 2 -> out = 8'h40 for 3 cycles, then 8'h80 for 3 cycles, then 8'h01 with wrap = 1 for that single cycle only, then 8'h02.
- Fast scan: dwell = 0, in = 0 -> out steps 01, 02, 04, ... 80, 01 on consecutive cycles; wrap is high on every 8th cycle; one-hot checked every cycle.
- Reload/reset mid-operation:
  - During SCAN at out = 8'h08, load mode = 0, in = 1 -> next cycle out = 8'h02, busy = 0, no wrap.
  - Assert rst_n low mid-scan -> out = 0 immediately, without waiting for a clk edge.
- With DECODER_SCAN_DIR_EN: load mode = 1, dir = 1, in = 1, dwell = 0 -> out 02, 01, 80 (wrap = 1), 40.
